// File: rtl/cmd_threshold_ctrl.sv
// Applies completed UART commands to the temperature/humidity thresholds and runs
// the fan/humidifier control: hysteresis auto mode plus a timed manual override.
module cmd_threshold_ctrl #(
    parameter logic [6:0] DEF_MAX_TEMP   = 7'd30,
    parameter logic [6:0] DEF_MIN_TEMP   = 7'd20,
    parameter logic [6:0] DEF_MAX_HUM    = 7'd70,
    parameter logic [6:0] DEF_MIN_HUM    = 7'd40,
    parameter int         MANUAL_TIMEOUT = 30_000_000
) (
    input  logic       clk_1Mhz,
    input  logic       rst_n,
    input  logic [7:0] chr_cmd,
    input  logic [7:0] chr_val0,
    input  logic [7:0] chr_val1,
    input  logic       rx_msg_done,
    input  logic [7:0] temperature,
    input  logic [7:0] humidity,
    input  logic       sensor_valid,
    output logic [6:0] max_temp,
    output logic [6:0] min_temp,
    output logic [6:0] max_hum,
    output logic [6:0] min_hum,
    output logic       fan_state,
    output logic       hum_state,
    output logic       manual_mode,
    output logic       cfg_update,
    output logic       cmd_err
);
    localparam logic [7:0]  CH_A = 8'h41, CH_B = 8'h42, CH_C = 8'h43, CH_D = 8'h44, CH_L = 8'h4C;
    localparam logic [25:0] TMO_LOAD = 26'(MANUAL_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, DECODE, APPLY} state_t;
    state_t state, state_nxt;

    logic       done_d, trigger;
    logic [7:0] cmd_r, val0_r, val1_r;
    logic [6:0] value_r;
    logic       dig_ok_r, bin_ok_r;
    logic       accept;
    logic [25:0] tmo_cnt;

    // done_d resets high so a level already asserted at reset release is not a new message
    assign trigger = rx_msg_done & ~done_d;

    always_ff @(posedge clk_1Mhz or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trigger) state_nxt = DECODE;
            DECODE:  state_nxt = APPLY;
            APPLY:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_1Mhz or negedge rst_n) begin
        if (!rst_n) begin
            done_d   <= 1'b1;
            cmd_r    <= '0;
            val0_r   <= '0;
            val1_r   <= '0;
            value_r  <= '0;
            dig_ok_r <= 1'b0;
            bin_ok_r <= 1'b0;
        end else begin
            done_d <= rx_msg_done;
            if (state == IDLE && trigger) begin
                cmd_r  <= chr_cmd;
                val0_r <= chr_val0;
                val1_r <= chr_val1;
            end
            if (state == DECODE) begin
                dig_ok_r <= (val0_r >= 8'h30) && (val0_r <= 8'h39) &&
                            (val1_r >= 8'h30) && (val1_r <= 8'h39);
                bin_ok_r <= (val0_r == 8'h30 || val0_r == 8'h31) &&
                            (val1_r == 8'h30 || val1_r == 8'h31);
                // low nibble of an ASCII digit is its value
                value_r  <= 7'(val0_r[3:0]) * 7'd10 + 7'(val1_r[3:0]);
            end
        end
    end

    always_comb begin
        accept = 1'b0;
        case (cmd_r)
            CH_A:    accept = dig_ok_r && (value_r > min_temp);
            CH_B:    accept = dig_ok_r && (value_r < max_temp);
            CH_C:    accept = dig_ok_r && (value_r > min_hum);
            CH_D:    accept = dig_ok_r && (value_r < max_hum);
            CH_L:    accept = bin_ok_r;
            default: accept = 1'b0;
        endcase
    end

    always_ff @(posedge clk_1Mhz or negedge rst_n) begin
        if (!rst_n) begin
            max_temp    <= DEF_MAX_TEMP;
            min_temp    <= DEF_MIN_TEMP;
            max_hum     <= DEF_MAX_HUM;
            min_hum     <= DEF_MIN_HUM;
            fan_state   <= 1'b0;
            hum_state   <= 1'b0;
            manual_mode <= 1'b0;
            cfg_update  <= 1'b0;
            cmd_err     <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            cfg_update <= 1'b0;
            cmd_err    <= 1'b0;
            if (manual_mode) begin
                if (tmo_cnt == '0) manual_mode <= 1'b0;
                else               tmo_cnt     <= tmo_cnt - 26'd1;
            end else if (sensor_valid) begin
                if (temperature > {1'b0, max_temp})      fan_state <= 1'b1;
                else if (temperature < {1'b0, min_temp}) fan_state <= 1'b0;
                if (humidity < {1'b0, min_hum})          hum_state <= 1'b1;
                else if (humidity > {1'b0, max_hum})     hum_state <= 1'b0;
            end
            // written last so an accepted 'L' overrides expiry and sensor decisions
            if (state == APPLY) begin
                if (accept) begin
                    cfg_update <= 1'b1;
                    case (cmd_r)
                        CH_A: max_temp <= value_r;
                        CH_B: min_temp <= value_r;
                        CH_C: max_hum  <= value_r;
                        CH_D: min_hum  <= value_r;
                        CH_L: begin
                            fan_state   <= val0_r[0];
                            hum_state   <= val1_r[0];
                            manual_mode <= 1'b1;
                            tmo_cnt     <= TMO_LOAD;
                        end
                        default: ;
                    endcase
                end else begin
                    cmd_err <= 1'b1;
                end
            end
        end
    end
endmodule
